// File: rtl/cross_ctrl.sv
// cross_ctrl: two-road intersection controller with a pedestrian walk phase
// and a night-time flashing-yellow mode. Road A rests on green. All lamp
// outputs are decoded from the state register and the blink bit only.
module cross_ctrl #(
  parameter int unsigned T_GREEN_A = 4,
  parameter int unsigned T_GREEN_B = 3,
  parameter int unsigned T_YEL     = 1,
  parameter int unsigned T_ALLRED  = 1,
  parameter int unsigned T_WALK    = 3,
  parameter int unsigned T_FLASH   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       modo,
  input  logic       sens_a,
  input  logic       sens_b,
  input  logic       ped_req,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic       walk,
  output logic       ped_wait
);

  typedef enum logic [2:0] {
    A_GREEN, A_YEL, RED1, WALK, B_GREEN, B_YEL, RED2, FLASH
  } state_e;

  localparam logic [2:0] LAMP_RED  = 3'b100;
  localparam logic [2:0] LAMP_YEL  = 3'b010;
  localparam logic [2:0] LAMP_GRN  = 3'b001;
  localparam logic [2:0] LAMP_DARK = 3'b000;

  // Last dwell-count value of each timed state (duration N exits at N-1).
  localparam logic [7:0] GA_LAST = 8'(T_GREEN_A - 1);
  localparam logic [7:0] GB_LAST = 8'(T_GREEN_B - 1);
  localparam logic [7:0] YL_LAST = 8'(T_YEL - 1);
  localparam logic [7:0] AR_LAST = 8'(T_ALLRED - 1);
  localparam logic [7:0] WK_LAST = 8'(T_WALK - 1);
  localparam logic [7:0] FL_LAST = 8'(T_FLASH - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ped_wait_q, ped_wait_d;
  logic       blink_q, blink_d;

  // Road A presence is informational only: A is the rest road.
  logic unused_sens_a;
  assign unused_sens_a = sens_a;

  // Next-state logic: timed phases exit at cnt==N-1; A green waits for demand.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      A_GREEN: if (cnt_q == GA_LAST && (modo || sens_b || ped_wait_q)) state_d = A_YEL;
      A_YEL:   if (cnt_q == YL_LAST) state_d = RED1;
      RED1: begin
        if (cnt_q == AR_LAST) begin
          if (modo)            state_d = FLASH;
          else if (ped_wait_q) state_d = WALK;
          else                 state_d = B_GREEN;
        end
      end
      WALK:    if (cnt_q == WK_LAST) state_d = B_GREEN;
      B_GREEN: if (cnt_q == GB_LAST) state_d = B_YEL;
      B_YEL:   if (cnt_q == YL_LAST) state_d = RED2;
      RED2:    if (cnt_q == AR_LAST) state_d = A_GREEN;
      FLASH:   if (!modo) state_d = RED2;
      default: state_d = A_GREEN;
    endcase
  end

  // Dwell counter and blink bit: clear on state change, saturate in A green,
  // wrap every half-period in FLASH with a blink toggle.
  always_comb begin
    cnt_d   = cnt_q + 8'd1;
    blink_d = blink_q;
    if (state_d != state_q) begin
      cnt_d   = 8'd0;
      blink_d = (state_d == FLASH);
    end else if (state_q == A_GREEN && cnt_q == GA_LAST) begin
      cnt_d = cnt_q;
    end else if (state_q == FLASH && cnt_q == FL_LAST) begin
      cnt_d   = 8'd0;
      blink_d = !blink_q;
    end
  end

  // Pedestrian latch: set by the button outside WALK/FLASH, cleared on entry
  // to either of them; the clear takes priority over a same-cycle press.
  always_comb begin
    ped_wait_d = ped_wait_q;
    if (state_d != state_q && (state_d == WALK || state_d == FLASH)) begin
      ped_wait_d = 1'b0;
    end else if (ped_req && state_q != WALK && state_q != FLASH) begin
      ped_wait_d = 1'b1;
    end
  end

  // State registers with synchronous reset back to a fresh A green.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= A_GREEN;
      cnt_q      <= 8'd0;
      ped_wait_q <= 1'b0;
      blink_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ped_wait_q <= ped_wait_d;
      blink_q    <= blink_d;
    end
  end

  // Moore lamp decode from state and blink bit.
  always_comb begin
    A    = LAMP_RED;
    B    = LAMP_RED;
    walk = 1'b0;
    unique case (state_q)
      A_GREEN: A = LAMP_GRN;
      A_YEL:   A = LAMP_YEL;
      WALK:    walk = 1'b1;
      B_GREEN: B = LAMP_GRN;
      B_YEL:   B = LAMP_YEL;
      FLASH: begin
        A = blink_q ? LAMP_YEL : LAMP_DARK;
        B = blink_q ? LAMP_YEL : LAMP_DARK;
      end
      default: ;
    endcase
  end

  assign ped_wait = ped_wait_q;

endmodule

// File: doc/cross_ctrl.md
CROSS_CTRL -- requirements
Module: cross_ctrl

Interface
REQ-001 Parameters (name, default, meaning), each SHALL be legal over 1..255:
- T_GREEN_A, 4, minimum road-A green cycles
- T_GREEN_B, 3, road-B green cycles
- T_YEL, 1, yellow cycles, either road
- T_ALLRED, 1, all-red clearance cycles
- T_WALK, 3, pedestrian walk cycles
- T_FLASH, 2, night-mode blink half-period cycles
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on rising edge
- reset, in, 1, synchronous, active-high
- modo, in, 1, 1 = night flashing mode requested
- sens_a, in, 1, vehicle present on road A (informational; A is rest road)
- sens_b, in, 1, vehicle present on road B
- ped_req, in, 1, pedestrian button; any-length pulse
- A, out, 3, road-A lamp, one-hot: 100 red, 010 yellow, 001 green, 000 dark
- B, out, 3, road-B lamp, same encoding
- walk, out, 1, pedestrian walk lamp
- ped_wait, out, 1, pedestrian request latched, not yet served

Function
REQ-003 States SHALL be A_GREEN, A_YEL, RED1, WALK, B_GREEN, B_YEL, RED2, FLASH; outputs SHALL be decoded from the state register (and blink bit) only (Moore).
REQ-004 Lamps per state (A/B/walk): A_GREEN 001/100/0; A_YEL 010/100/0; RED1, RED2 100/100/0; WALK 100/100/1; B_GREEN 100/001/0; B_YEL 100/010/0; FLASH blink?010:000 on both roads, walk 0.
REQ-005 An 8-bit dwell counter SHALL clear to 0 on every state change and increment each cycle; a state of duration N SHALL exit on the cycle cnt==N-1, giving exactly N cycles.
REQ-006 In A_GREEN, cnt SHALL saturate at T_GREEN_A-1; once saturated, exit to A_YEL when modo|sens_b|ped_wait is 1, else hold indefinitely.
REQ-007 Fixed sequence: A_YEL->RED1; B_GREEN->B_YEL->RED2->A_GREEN; WALK->B_GREEN.
REQ-008 RED1 exit priority: modo=1 -> FLASH; else ped_wait=1 -> WALK; else B_GREEN.
REQ-009 FLASH: blink bit SHALL toggle every T_FLASH cycles, starting at 1 on entry; when modo=0 is sampled, next state SHALL be RED2 (any blink phase).
REQ-010 modo changes SHALL take effect only via REQ-006/REQ-008/REQ-009; a green or yellow phase SHALL never be truncated.
REQ-011 ped_wait SHALL set on any cycle with ped_req=1 except in WALK or FLASH (ignored there); ped_wait SHALL clear on entry to WALK and on entry to FLASH; clear wins over a simultaneous set.
REQ-012 A and B SHALL never both be non-red except in FLASH; walk=1 only when A=B=100.

Reset
REQ-013 While reset=1 at a rising edge: state A_GREEN, cnt 0, ped_wait 0, blink 0; outputs A=001, B=100, walk=0 the following cycle; reset SHALL override any state, including mid-phase.

Verification
REQ-014 Defaults; release reset, hold sens_b=1 -> A green cycles 0-3, A yellow 4, all-red 5, B green 6-8, B yellow 9, all-red 10, A green from 11.
REQ-015 No sens_b, ped_req, modo for 100 cycles -> A=001, B=100 throughout, cnt stays 3.
REQ-016 ped_req one-cycle pulse at cycle 10 -> ped_wait=1 at 11; A yellow 1 cycle, all-red 1 cycle, walk=1 with A=B=100 for exactly 3 cycles, ped_wait=0 from WALK entry, then B green 3 cycles.
REQ-017 modo=1 at cycle 10 -> A yellow, all-red, then A=B alternating 010 (2 cycles)/000 (2 cycles); ped_req during FLASH leaves ped_wait=0; modo=0 -> one all-red cycle then A=001.
REQ-018 reset=1 for one cycle during B_GREEN with ped_wait=1 -> next cycle A=001, B=100, walk=0, ped_wait=0; full A green minimum re-served.
REQ-019 Random sens_b/ped_req/modo for 10000 cycles -> REQ-012 assertion never fires; every non-flash phase length matches its parameter.
